controler_intersectie: RTL and testbench

Main phase sequencer for the signalised intersection. Steps the 3-bit phase code `stare_semafor` through the vehicle phases and, on demand, the pedestrian phase. It drives the pedestrian light stage directly downstream and consumes that stage's `ready_P` completion pulse. All timing is counted in 1 s enable ticks from the existing clock divider.

---
 rtl/controler_intersectie.sv | 172 +++++++++++++++++
 tb/tb_controler_intersectie.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/controler_intersectie.sv
// ---------------------------------------------------------------------------
// controler_intersectie
//   Main phase sequencer for the signalised intersection. Steps the phase
//   code through the vehicle phases (all-red, NS green/yellow, EW
//   green/yellow), optionally the pedestrian phase, and a night (flashing)
//   phase. All durations are counted in 1 s enable ticks.
//
// Ports
//   clk            system clock
//   rst            synchronous, active-high reset
//   tick_1s        one-clk enable pulse, once per second
//   buton_P        pedestrian request button (level, debounced)
//   ready_P        one-clk pulse from the pedestrian stage: cycle finished
//   mod_noapte     night mode request (level)
//   stare_semafor  current phase code (registered)
//   cerere_P       latched pedestrian request ("wait" indicator)
//   faza_noua      one-clk pulse in the first cycle a new phase is visible
//   eroare_P       sticky pedestrian watchdog flag, cleared only by rst
// ---------------------------------------------------------------------------
module controler_intersectie #(
    parameter int T_ROSU_TOT  = 2,
    parameter int T_VERDE_NS  = 20,
    parameter int T_VERDE_EW  = 15,
    parameter int T_GALBEN    = 3,
    parameter int T_P_TIMEOUT = 30,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1s,
    input  logic       buton_P,
    input  logic       ready_P,
    input  logic       mod_noapte,
    output logic [2:0] stare_semafor,
    output logic       cerere_P,
    output logic       faza_noua,
    output logic       eroare_P
);

    typedef enum logic [2:0] {
        ROSU_TOT  = 3'b000,
        NS_VERDE  = 3'b001,
        NS_GALBEN = 3'b010,
        EW_VERDE  = 3'b011,
        PIETONI   = 3'b100,
        EW_GALBEN = 3'b101,
        NOAPTE    = 3'b111
    } faza_t;

    // Terminal counter values: a phase of duration T exits on the tick
    // seen while the counter holds T-1.
    localparam logic [CNT_W-1:0] LIM_ROSU  = CNT_W'(T_ROSU_TOT - 1);
    localparam logic [CNT_W-1:0] LIM_NS    = CNT_W'(T_VERDE_NS - 1);
    localparam logic [CNT_W-1:0] LIM_EW    = CNT_W'(T_VERDE_EW - 1);
    localparam logic [CNT_W-1:0] LIM_GALB  = CNT_W'(T_GALBEN - 1);
    localparam logic [CNT_W-1:0] LIM_PIET  = CNT_W'(T_P_TIMEOUT - 1);

    // The phase register is a plain vector so the unused code 110 is
    // representable and can be steered back to all-red.
    logic [2:0]       stare_q, stare_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cerere_q, cerere_d;
    logic             faza_q, faza_d;
    logic             eroare_q, eroare_d;

    logic exp_rosu, exp_ns, exp_ew, exp_galb, exp_piet;
    logic intrare_blocata;

    assign exp_rosu = tick_1s && (cnt_q == LIM_ROSU);
    assign exp_ns   = tick_1s && (cnt_q == LIM_NS);
    assign exp_ew   = tick_1s && (cnt_q == LIM_EW);
    assign exp_galb = tick_1s && (cnt_q == LIM_GALB);
    assign exp_piet = tick_1s && (cnt_q == LIM_PIET);

    // Next phase
    always_comb begin
        stare_d  = stare_q;
        eroare_d = eroare_q;
        case (stare_q)
            ROSU_TOT: begin
                if (exp_rosu) begin
                    stare_d = mod_noapte ? NOAPTE : NS_VERDE;
                end
            end
            NS_VERDE: begin
                // Night request cuts a green short; yellow always runs full.
                if (mod_noapte || exp_ns) begin
                    stare_d = NS_GALBEN;
                end
            end
            NS_GALBEN: begin
                if (exp_galb) begin
                    stare_d = EW_VERDE;
                end
            end
            EW_VERDE: begin
                if (mod_noapte || exp_ew) begin
                    stare_d = EW_GALBEN;
                end
            end
            EW_GALBEN: begin
                if (exp_galb) begin
                    stare_d = cerere_q ? PIETONI : ROSU_TOT;
                end
            end
            PIETONI: begin
                // A normal completion in the same cycle as watchdog expiry
                // is treated as a clean exit.
                if (ready_P) begin
                    stare_d = ROSU_TOT;
                end else if (exp_piet) begin
                    stare_d  = ROSU_TOT;
                    eroare_d = 1'b1;
                end
            end
            NOAPTE: begin
                if (!mod_noapte) begin
                    stare_d = ROSU_TOT;
                end
            end
            default: begin
                stare_d = ROSU_TOT;
            end
        endcase
    end

    // Counter, request latch and phase-change pulse
    always_comb begin
        cnt_d    = cnt_q;
        cerere_d = cerere_q;
        faza_d   = (stare_d != stare_q);

        if (stare_d != stare_q) begin
            cnt_d = '0;
        end else if (tick_1s) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Requests are not accepted while pedestrians walk or at night;
        // entering either phase consumes the request and beats a
        // simultaneous press.
        intrare_blocata = ((stare_d == PIETONI) && (stare_q != PIETONI)) ||
                          ((stare_d == NOAPTE)  && (stare_q != NOAPTE));
        if (intrare_blocata) begin
            cerere_d = 1'b0;
        end else if (buton_P && (stare_q != PIETONI) && (stare_q != NOAPTE)) begin
            cerere_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stare_q  <= ROSU_TOT;
            cnt_q    <= '0;
            cerere_q <= 1'b0;
            faza_q   <= 1'b0;
            eroare_q <= 1'b0;
        end else begin
            stare_q  <= stare_d;
            cnt_q    <= cnt_d;
            cerere_q <= cerere_d;
            faza_q   <= faza_d;
            eroare_q <= eroare_d;
        end
    end

    assign stare_semafor = stare_q;
    assign cerere_P      = cerere_q;
    assign faza_noua     = faza_q;
    assign eroare_P      = eroare_q;

endmodule

// File: tb/tb_controler_intersectie.sv
module tb_controler_intersectie;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1s;
    logic       buton_P;
    logic       ready_P;
    logic       mod_noapte;
    logic [2:0] stare_semafor;
    logic       cerere_P;
    logic       faza_noua;
    logic       eroare_P;

    int n_cmp = 0;
    int n_bad = 0;

    controler_intersectie #(
        .T_ROSU_TOT (2),
        .T_VERDE_NS (4),
        .T_VERDE_EW (3),
        .T_GALBEN   (2),
        .T_P_TIMEOUT(5),
        .CNT_W      (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_1s      (tick_1s),
        .buton_P      (buton_P),
        .ready_P      (ready_P),
        .mod_noapte   (mod_noapte),
        .stare_semafor(stare_semafor),
        .cerere_P     (cerere_P),
        .faza_noua    (faza_noua),
        .eroare_P     (eroare_P)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic do_tick();
        repeat (3) @(negedge clk);
        tick_1s = 1'b1;
        @(negedge clk);
        tick_1s = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; tick_1s = 1'b0; buton_P = 1'b0; ready_P = 1'b0; mod_noapte = 1'b0;
        apply_reset();
        n_cmp++; if (stare_semafor !== 3'b000) begin n_bad++; $display("FAIL reset_stare: got %b expected 000", stare_semafor); end
        n_cmp++; if (cerere_P !== 1'b0) begin n_bad++; $display("FAIL reset_cerere: got %b expected 0", cerere_P); end
        n_cmp++; if (faza_noua !== 1'b0) begin n_bad++; $display("FAIL reset_faza: got %b expected 0", faza_noua); end
        n_cmp++; if (eroare_P !== 1'b0) begin n_bad++; $display("FAIL reset_eroare: got %b expected 0", eroare_P); end
        $display("test_reset done");
    endtask

    task automatic test_free_run();
        logic [2:0] seq [13] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010,
                                 3'b011, 3'b011, 3'b011, 3'b101, 3'b101, 3'b000};
        logic [2:0] prev;
        logic       exp_f;
        apply_reset();
        prev = 3'b000;
        for (int i = 0; i < 13; i++) begin
            do_tick();
            exp_f = (seq[i] != prev);
            n_cmp++; if (stare_semafor !== seq[i]) begin n_bad++; $display("FAIL free_run_stare[%0d]: got %b expected %b", i, stare_semafor, seq[i]); end
            n_cmp++; if (faza_noua !== exp_f) begin n_bad++; $display("FAIL free_run_faza[%0d]: got %b expected %b", i, faza_noua, exp_f); end
            prev = seq[i];
        end
        @(negedge clk);
        n_cmp++; if (faza_noua !== 1'b0) begin n_bad++; $display("FAIL free_run_faza_width: got %b expected 0", faza_noua); end
        $display("test_free_run done");
    endtask

    task automatic test_ped_request();
        apply_reset();
        repeat (2) do_tick();
        n_cmp++; if (stare_semafor !== 3'b001) begin n_bad++; $display("FAIL ped_in_001: got %b expected 001", stare_semafor); end
        buton_P = 1'b1;
        @(negedge clk);
        buton_P = 1'b0;
        n_cmp++; if (cerere_P !== 1'b1) begin n_bad++; $display("FAIL ped_cerere_set: got %b expected 1", cerere_P); end
        repeat (11) do_tick();
        n_cmp++; if (stare_semafor !== 3'b100) begin n_bad++; $display("FAIL ped_enter_100: got %b expected 100", stare_semafor); end
        n_cmp++; if (cerere_P !== 1'b0) begin n_bad++; $display("FAIL ped_cerere_clr: got %b expected 0", cerere_P); end
        n_cmp++; if (faza_noua !== 1'b1) begin n_bad++; $display("FAIL ped_faza_enter: got %b expected 1", faza_noua); end
        repeat (3) do_tick();
        n_cmp++; if (stare_semafor !== 3'b100) begin n_bad++; $display("FAIL ped_hold_100: got %b expected 100", stare_semafor); end
        ready_P = 1'b1;
        @(negedge clk);
        ready_P = 1'b0;
        n_cmp++; if (stare_semafor !== 3'b000) begin n_bad++; $display("FAIL ped_ready_exit: got %b expected 000", stare_semafor); end
        n_cmp++; if (faza_noua !== 1'b1) begin n_bad++; $display("FAIL ped_ready_faza: got %b expected 1", faza_noua); end
        n_cmp++; if (eroare_P !== 1'b0) begin n_bad++; $display("FAIL ped_ready_eroare: got %b expected 0", eroare_P); end
        $display("test_ped_request done");
    endtask

    task automatic test_watchdog();
        apply_reset();
        buton_P = 1'b1;
        @(negedge clk);
        buton_P = 1'b0;
        repeat (13) do_tick();
        n_cmp++; if (stare_semafor !== 3'b100) begin n_bad++; $display("FAIL wd_enter_100: got %b expected 100", stare_semafor); end
        repeat (4) do_tick();
        n_cmp++; if (stare_semafor !== 3'b100) begin n_bad++; $display("FAIL wd_before_expiry: got %b expected 100", stare_semafor); end
        n_cmp++; if (eroare_P !== 1'b0) begin n_bad++; $display("FAIL wd_eroare_early: got %b expected 0", eroare_P); end
        do_tick();
        n_cmp++; if (stare_semafor !== 3'b000) begin n_bad++; $display("FAIL wd_exit: got %b expected 000", stare_semafor); end
        n_cmp++; if (eroare_P !== 1'b1) begin n_bad++; $display("FAIL wd_eroare_set: got %b expected 1", eroare_P); end
        repeat (6) do_tick();
        n_cmp++; if (eroare_P !== 1'b1) begin n_bad++; $display("FAIL wd_eroare_sticky: got %b expected 1", eroare_P); end
        apply_reset();
        n_cmp++; if (eroare_P !== 1'b0) begin n_bad++; $display("FAIL wd_eroare_rst: got %b expected 0", eroare_P); end
        $display("test_watchdog done");
    endtask

    task automatic test_night();
        apply_reset();
        repeat (3) do_tick();
        mod_noapte = 1'b1;
        @(negedge clk);
        n_cmp++; if (stare_semafor !== 3'b010) begin n_bad++; $display("FAIL night_cut_ns: got %b expected 010", stare_semafor); end
        n_cmp++; if (faza_noua !== 1'b1) begin n_bad++; $display("FAIL night_cut_faza: got %b expected 1", faza_noua); end
        do_tick();
        n_cmp++; if (stare_semafor !== 3'b010) begin n_bad++; $display("FAIL night_yellow_full: got %b expected 010", stare_semafor); end
        do_tick();
        n_cmp++; if (stare_semafor !== 3'b011) begin n_bad++; $display("FAIL night_ew_green: got %b expected 011", stare_semafor); end
        @(negedge clk);
        n_cmp++; if (stare_semafor !== 3'b101) begin n_bad++; $display("FAIL night_cut_ew: got %b expected 101", stare_semafor); end
        do_tick();
        n_cmp++; if (stare_semafor !== 3'b101) begin n_bad++; $display("FAIL night_ew_yellow: got %b expected 101", stare_semafor); end
        do_tick();
        n_cmp++; if (stare_semafor !== 3'b000) begin n_bad++; $display("FAIL night_to_red: got %b expected 000", stare_semafor); end
        repeat (2) do_tick();
        n_cmp++; if (stare_semafor !== 3'b111) begin n_bad++; $display("FAIL night_enter: got %b expected 111", stare_semafor); end
        repeat (10) @(negedge clk);
        n_cmp++; if (stare_semafor !== 3'b111) begin n_bad++; $display("FAIL night_hold: got %b expected 111", stare_semafor); end
        mod_noapte = 1'b0;
        @(negedge clk);
        n_cmp++; if (stare_semafor !== 3'b000) begin n_bad++; $display("FAIL night_exit: got %b expected 000", stare_semafor); end
        n_cmp++; if (faza_noua !== 1'b1) begin n_bad++; $display("FAIL night_exit_faza: got %b expected 1", faza_noua); end
        $display("test_night done");
    endtask

    task automatic test_button_blocked();
        apply_reset();
        buton_P = 1'b1;
        repeat (13) do_tick();
        n_cmp++; if (stare_semafor !== 3'b100) begin n_bad++; $display("FAIL blk_enter_100: got %b expected 100", stare_semafor); end
        n_cmp++; if (cerere_P !== 1'b0) begin n_bad++; $display("FAIL blk_entry_clear_wins: got %b expected 0", cerere_P); end
        repeat (5) @(negedge clk);
        n_cmp++; if (cerere_P !== 1'b0) begin n_bad++; $display("FAIL blk_held_in_100: got %b expected 0", cerere_P); end
        ready_P = 1'b1;
        @(negedge clk);
        ready_P = 1'b0;
        n_cmp++; if (cerere_P !== 1'b0) begin n_bad++; $display("FAIL blk_exit_edge: got %b expected 0", cerere_P); end
        @(negedge clk);
        n_cmp++; if (cerere_P !== 1'b1) begin n_bad++; $display("FAIL blk_rearm_in_000: got %b expected 1", cerere_P); end
        mod_noapte = 1'b1;
        repeat (2) do_tick();
        n_cmp++; if (stare_semafor !== 3'b111) begin n_bad++; $display("FAIL blk_enter_111: got %b expected 111", stare_semafor); end
        n_cmp++; if (cerere_P !== 1'b0) begin n_bad++; $display("FAIL blk_night_clear: got %b expected 0", cerere_P); end
        repeat (5) @(negedge clk);
        n_cmp++; if (cerere_P !== 1'b0) begin n_bad++; $display("FAIL blk_held_in_111: got %b expected 0", cerere_P); end
        buton_P = 1'b0;
        mod_noapte = 1'b0;
        @(negedge clk);
        n_cmp++; if (stare_semafor !== 3'b000) begin n_bad++; $display("FAIL blk_night_exit: got %b expected 000", stare_semafor); end
        $display("test_button_blocked done");
    endtask

    task automatic test_reset_mid_phase();
        apply_reset();
        repeat (8) do_tick();
        n_cmp++; if (stare_semafor !== 3'b011) begin n_bad++; $display("FAIL mid_in_011: got %b expected 011", stare_semafor); end
        buton_P = 1'b1;
        @(negedge clk);
        buton_P = 1'b0;
        repeat (2) do_tick();
        repeat (3) @(negedge clk);
        tick_1s = 1'b1;
        ready_P = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        tick_1s = 1'b0;
        ready_P = 1'b0;
        rst = 1'b0;
        n_cmp++; if (stare_semafor !== 3'b000) begin n_bad++; $display("FAIL mid_rst_stare: got %b expected 000", stare_semafor); end
        n_cmp++; if (faza_noua !== 1'b0) begin n_bad++; $display("FAIL mid_rst_faza: got %b expected 0", faza_noua); end
        n_cmp++; if (cerere_P !== 1'b0) begin n_bad++; $display("FAIL mid_rst_cerere: got %b expected 0", cerere_P); end
        n_cmp++; if (eroare_P !== 1'b0) begin n_bad++; $display("FAIL mid_rst_eroare: got %b expected 0", eroare_P); end
        // Counter restarted at 0: all-red needs both ticks again.
        do_tick();
        n_cmp++; if (stare_semafor !== 3'b000) begin n_bad++; $display("FAIL mid_rst_cnt1: got %b expected 000", stare_semafor); end
        do_tick();
        n_cmp++; if (stare_semafor !== 3'b001) begin n_bad++; $display("FAIL mid_rst_cnt2: got %b expected 001", stare_semafor); end
        // Illegal code recovery
        @(negedge clk);
        force dut.stare_q = 3'b110;
        #1;
        release dut.stare_q;
        @(negedge clk);
        n_cmp++; if (stare_semafor !== 3'b000) begin n_bad++; $display("FAIL illegal_recover: got %b expected 000", stare_semafor); end
        n_cmp++; if (faza_noua !== 1'b1) begin n_bad++; $display("FAIL illegal_faza: got %b expected 1", faza_noua); end
        $display("test_reset_mid_phase done");
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_ped_request();
        test_watchdog();
        test_night();
        test_button_blocked();
        test_reset_mid_phase();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
